// File: rtl/wb_test_status_pkg.sv
// Shared types and register map for the wb_test_status mailbox.
// State encoding, byte offsets, CTRL bits and STATUS field positions.
package wb_test_status_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_PASS = 3'd2,
        S_FAIL = 3'd3,
        S_TMO  = 3'd4
    } state_e;

    localparam int unsigned OFF_CTRL   = 32'h00;
    localparam int unsigned OFF_STATUS = 32'h04;
    localparam int unsigned OFF_WDOG   = 32'h08;
    localparam int unsigned OFF_KICK   = 32'h0C;
    localparam int unsigned OFF_GOLDEN = 32'h10;

    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_CLEAR_BIT = 1;

    localparam int unsigned STAT_STATE_LSB = 0;
    localparam int unsigned STAT_PASS_BIT  = 3;
    localparam int unsigned STAT_FAIL_BIT  = 4;
    localparam int unsigned STAT_TMO_BIT   = 5;
    localparam int unsigned STAT_PERR_BIT  = 6;
    localparam int unsigned STAT_OVF_BIT   = 7;
    localparam int unsigned STAT_FCH_LSB   = 8;
    localparam int unsigned STAT_MASK_LSB  = 16;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/wb_test_status_if.sv
// Wishbone-classic bus bundle for wb_test_status; signal names are from the slave's view.
interface wb_test_status_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] wb_adr_i;
    logic [31:0]       wb_dat_i;
    logic [31:0]       wb_dat_o;
    logic [3:0]        wb_sel_i;
    logic              wb_we_i;
    logic              wb_stb_i;
    logic              wb_cyc_i;
    logic              wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_test_status_trace.sv
// Ring-buffer FIFO of RESULT writes; a push into a full ring drops the oldest entry and sets ovf.
module wb_test_status_trace #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 32,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic [CW-1:0] cnt_o,
    output logic          ovf_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          full, empty;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (push_i) begin
            wr_q <= wr_q + AW'(1);
            if (full) begin
                rd_q  <= rd_q + AW'(1);
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else if (pop_i && !empty) begin
            rd_q  <= rd_q + AW'(1);
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Storage carries no reset; the count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[wr_q] <= data_i;
    end

    assign data_o = empty ? '0 : mem_q[rd_q];
    assign cnt_o  = cnt_q;
    assign ovf_o  = ovf_q;
endmodule

// File: rtl/wb_test_status.sv
// Wishbone-classic pass/fail mailbox: per-channel golden/result compare, kickable watchdog, sticky verdicts.
// Define TESTSTAT_TRACE_EN to build the RESULT-write trace ring (wb_test_status_trace).
module wb_test_status
    import wb_test_status_pkg::*;
#(
    parameter int unsigned       NUM_CH      = 4,
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       TMO_W       = 24,
    parameter logic [TMO_W-1:0]  TMO_RST     = 'hF4240,
    parameter int unsigned       TRACE_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_test_status_if.slave  bus,
    output logic             pass_o,
    output logic             fail_o,
    output logic             timeout_o,
    output logic             done_o,
    output logic [3:0]       fail_ch_o
);
    localparam int unsigned W_CTRL = OFF_CTRL >> 2;
    localparam int unsigned W_STAT = OFF_STATUS >> 2;
    localparam int unsigned W_WDOG = OFF_WDOG >> 2;
    localparam int unsigned W_KICK = OFF_KICK >> 2;
    localparam int unsigned W_GOLD = OFF_GOLDEN >> 2;
    localparam int unsigned W_RES  = W_GOLD + NUM_CH;
    localparam int unsigned W_POP  = W_GOLD + 2 * NUM_CH;
    localparam int unsigned W_CNT  = W_POP + 1;
    localparam int unsigned TRC_CW = $clog2(TRACE_DEPTH) + 1;

    state_e             state_q;
    logic               ack_q;
    logic [31:0]        dat_q;
    logic               pass_q, fail_q, tmo_q, perr_q;
    logic [3:0]         fail_ch_q;
    logic [NUM_CH-1:0]  checked_q;
    logic [TMO_W-1:0]   wdog_load_q, wdog_q;
    logic [31:0]        golden_q [NUM_CH];
    logic [31:0]        result_q [NUM_CH];

    logic               fire, wr, rd, run;
    int unsigned        widx;
    logic [NUM_CH-1:0]  gold_hit, res_hit;
    logic [3:0]         res_ch;
    logic               mismatch, all_match;
    logic               res_wr, res_ok, kick_wr, ctrl_wr, clear, start;
    logic               pass_now, fail_now, expire;
    logic [31:0]        status_d, rdata_d;
    logic [31:0]        trace_dat;
    logic [TRC_CW-1:0]  trace_cnt;
    logic               trace_ovf;
    logic               unused_adr;

    assign unused_adr = ^bus.wb_adr_i[1:0];

    // A bus access takes effect on the edge that raises ack.
    assign fire = bus.wb_stb_i & bus.wb_cyc_i & ~ack_q;
    assign wr   = fire & bus.wb_we_i;
    assign rd   = fire & ~bus.wb_we_i;
    assign run  = (state_q == S_RUN);
    assign widx = 32'(bus.wb_adr_i[ADDR_W-1:2]);

    always_comb begin
        gold_hit  = '0;
        res_hit   = '0;
        res_ch    = '0;
        mismatch  = 1'b0;
        all_match = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            gold_hit[i] = (widx == W_GOLD + i);
            res_hit[i]  = (widx == W_RES + i);
            if (res_hit[i]) res_ch = 4'(i);
            if (res_hit[i] && bus.wb_dat_i != golden_q[i]) mismatch = 1'b1;
            if ((res_hit[i] ? bus.wb_dat_i : result_q[i]) != golden_q[i]) all_match = 1'b0;
        end
    end

    assign res_wr   = wr & (|res_hit);
    assign res_ok   = res_wr & (bus.wb_sel_i == 4'hF);
    assign kick_wr  = wr & (widx == W_KICK);
    assign ctrl_wr  = wr & (widx == W_CTRL) & bus.wb_sel_i[0];
    assign clear    = ctrl_wr & bus.wb_dat_i[CTRL_CLEAR_BIT];
    assign start    = ctrl_wr & bus.wb_dat_i[CTRL_START_BIT] & ~bus.wb_dat_i[CTRL_CLEAR_BIT];
    assign fail_now = run & res_ok & mismatch;
    assign pass_now = run & res_ok & ~mismatch & all_match & (&(checked_q | res_hit));
    // A verdict from a RESULT write or a KICK on the expiry edge beats the timeout.
    assign expire   = run & (wdog_q == TMO_W'(1)) & ~kick_wr & ~pass_now & ~fail_now;

    always_comb begin
        status_d = '0;
        status_d[STAT_STATE_LSB +: 3] = state_q;
        status_d[STAT_PASS_BIT]       = pass_q;
        status_d[STAT_FAIL_BIT]       = fail_q;
        status_d[STAT_TMO_BIT]        = tmo_q;
        status_d[STAT_PERR_BIT]       = perr_q;
        status_d[STAT_OVF_BIT]        = trace_ovf;
        status_d[STAT_FCH_LSB +: 4]   = fail_ch_q;
        status_d[STAT_MASK_LSB +: NUM_CH] = checked_q;
    end

    always_comb begin
        rdata_d = '0;
        if (widx == W_STAT) rdata_d = status_d;
        if (widx == W_WDOG) rdata_d = 32'(wdog_load_q);
        if (widx == W_POP)  rdata_d = trace_dat;
        if (widx == W_CNT)  rdata_d = 32'(trace_cnt);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (gold_hit[i]) rdata_d = golden_q[i];
            if (res_hit[i])  rdata_d = result_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            tmo_q       <= 1'b0;
            perr_q      <= 1'b0;
            fail_ch_q   <= '0;
            checked_q   <= '0;
            wdog_load_q <= TMO_RST;
            wdog_q      <= TMO_RST;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                golden_q[i] <= '0;
                result_q[i] <= '0;
            end
        end else begin
            ack_q <= bus.wb_stb_i & bus.wb_cyc_i & ~ack_q;
            if (rd) dat_q <= rdata_d;
            if (wr && widx == W_WDOG)
                wdog_load_q <= TMO_W'(merge_bytes(32'(wdog_load_q), bus.wb_dat_i, bus.wb_sel_i));
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (wr && gold_hit[i]) golden_q[i] <= merge_bytes(golden_q[i], bus.wb_dat_i, bus.wb_sel_i);
                if (res_ok && res_hit[i]) result_q[i] <= bus.wb_dat_i;
            end
            if (res_wr && !res_ok) perr_q <= 1'b1;

            if (kick_wr) wdog_q <= wdog_load_q;
            else if (run && wdog_q != '0) wdog_q <= wdog_q - TMO_W'(1);

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_RUN;
                        wdog_q    <= wdog_load_q;
                        checked_q <= '0;
                    end
                end
                S_RUN: begin
                    if (res_ok) checked_q <= checked_q | res_hit;
                    if (fail_now) begin
                        state_q   <= S_FAIL;
                        fail_q    <= 1'b1;
                        fail_ch_q <= res_ch;
                    end else if (pass_now) begin
                        state_q <= S_PASS;
                        pass_q  <= 1'b1;
                    end else if (expire) begin
                        state_q <= S_TMO;
                        tmo_q   <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (clear) begin
                state_q   <= S_IDLE;
                pass_q    <= 1'b0;
                fail_q    <= 1'b0;
                tmo_q     <= 1'b0;
                perr_q    <= 1'b0;
                fail_ch_q <= '0;
                checked_q <= '0;
            end
        end
    end

`ifdef TESTSTAT_TRACE_EN
    wb_test_status_trace #(
        .DEPTH (TRACE_DEPTH),
        .W     (32)
    ) u_trace (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clear),
        .push_i (res_ok),
        .data_i ({res_ch, bus.wb_dat_i[27:0]}),
        .pop_i  (rd && widx == W_POP),
        .data_o (trace_dat),
        .cnt_o  (trace_cnt),
        .ovf_o  (trace_ovf)
    );
`else
    assign trace_dat = '0;
    assign trace_cnt = '0;
    assign trace_ovf = 1'b0;
`endif

    assign bus.wb_ack_o = ack_q;
    assign bus.wb_dat_o = dat_q;
    assign pass_o       = pass_q;
    assign fail_o       = fail_q;
    assign timeout_o    = tmo_q;
    assign done_o       = pass_q | fail_q | tmo_q;
    assign fail_ch_o    = fail_ch_q;
endmodule
